// File: rtl/execute_pkg.sv
// Shared types for the integer execute unit: opcode encoding and control states.
package execute_pkg;
  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_REM = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } op_e;

  typedef enum logic {
    IDLE    = 1'b0,
    DIV_RUN = 1'b1
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction
endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, WIDTH cycles after start.
// done/quotient/remainder are combinational on the final iteration so the caller can register them.
module serial_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;

  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // r_quo doubles as the dividend shift register: its MSB feeds the remainder each step.
  assign w_trial    = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
  assign w_fits     = !w_trial[WIDTH];
  assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

  assign done      = r_busy && (r_cnt == '0);
  assign quotient  = w_quo_next;
  assign remainder = w_rem_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(WIDTH - 1);
      r_rem  <= '0;
      r_quo  <= dividend;
      r_dvs  <= divisor;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/execute_unit.sv
// WIDTH-bit integer execute stage: single-cycle ALU ops plus iterative DIV/REM, valid/ready on both sides.
// Results and flags are registered and held while the consumer stalls.
module execute_unit
  import execute_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] src1_value,
  input  logic [WIDTH-1:0] src2_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_dz
);
  state_e           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_dz;
  logic             r_is_rem;

  op_e                w_op;
  logic               w_accept;
  logic               w_src2_zero;
  logic               w_div_start;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_carry;
  logic               w_alu_dz;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_div_quo;
  logic [WIDTH-1:0]   w_div_rem;
  logic [WIDTH-1:0]   w_div_res;

  assign w_op        = op_e'(op);
  assign in_ready    = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_src2_zero = (src2_value == '0);
  // Divide-by-zero resolves in the ALU path, so only a real division engages the divider.
  assign w_div_start = w_accept && is_div_op(w_op) && !w_src2_zero;
  assign w_sum       = {1'b0, src1_value} + {1'b0, src2_value};
  assign w_prod      = src1_value * src2_value;
  assign w_div_res   = r_is_rem ? w_div_rem : w_div_quo;

  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_dz    = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_res   = src1_value - src2_value;
        w_alu_carry = (src1_value < src2_value);
      end
      OP_MUL: begin
        w_alu_res   = w_prod[WIDTH-1:0];
        w_alu_carry = |w_prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        w_alu_res = '1;
        w_alu_dz  = w_src2_zero;
      end
      OP_REM: begin
        w_alu_res = src1_value;
        w_alu_dz  = w_src2_zero;
      end
      OP_AND:  w_alu_res = src1_value & src2_value;
      OP_OR:   w_alu_res = src1_value | src2_value;
      OP_XOR:  w_alu_res = src1_value ^ src2_value;
      default: w_alu_res = '0;
    endcase
  end

  serial_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (w_div_start),
    .dividend  (src1_value),
    .divisor   (src2_value),
    .done      (w_div_done),
    .quotient  (w_div_quo),
    .remainder (w_div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_dz        <= 1'b0;
      r_is_rem    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_out_valid && out_ready) r_out_valid <= 1'b0;
          if (w_div_start) begin
            r_state  <= DIV_RUN;
            r_is_rem <= (w_op == OP_REM);
          end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu_res;
            r_zero      <= (w_alu_res == '0);
            r_carry     <= w_alu_carry;
            r_dz        <= w_alu_dz;
          end
        end
        DIV_RUN: begin
          if (w_div_done) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b1;
            r_result    <= w_div_res;
            r_zero      <= (w_div_res == '0);
            r_carry     <= 1'b0;
            r_dz        <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign flag_zero  = r_zero;
  assign flag_carry = r_carry;
  assign flag_dz    = r_dz;
endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: directed cases plus randomized ops against an arithmetic reference model.
module tb_execute_unit;
  localparam int W = 8;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3,
                         REM = 3'd4, AND = 3'd5, OR = 3'd6, XOR = 3'd7;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] src1_value;
  logic [W-1:0] src2_value;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_dz;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  execute_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .src1_value (src1_value),
    .src2_value (src2_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_dz    (flag_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {dz, carry, zero, result} straight from the unsigned arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] o, input int unsigned a, input int unsigned b);
    int unsigned mask, full, res;
    logic c, dz;
    mask = (1 << W) - 1;
    c = 1'b0; dz = 1'b0; res = 0;
    case (o)
      ADD: begin full = a + b; res = full & mask; c = (full > mask); end
      SUB: begin res = (a - b) & mask; c = (a < b); end
      MUL: begin full = a * b; res = full & mask; c = ((full >> W) != 0); end
      DIV: if (b == 0) begin res = mask; dz = 1'b1; end else res = a / b;
      REM: if (b == 0) begin res = a;    dz = 1'b1; end else res = a % b;
      AND: res = a & b;
      OR:  res = a | b;
      default: res = a ^ b;
    endcase
    return {21'd0, dz, c, (res == 0), res[W-1:0]};
  endfunction

  // Monitor: every output transfer is checked against the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {21'd0, flag_dz, flag_carry, flag_zero, result}, 32'hFFFF_FFFF);
      end else begin
        check("result_flags", {21'd0, flag_dz, flag_carry, flag_zero, result}, exp_q.pop_front());
      end
    end
  end

  bit rand_rdy = 1'b0;

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input int unsigned a, input int unsigned b, output int stalls);
    in_valid   = 1'b1;
    op         = o;
    src1_value = a[W-1:0];
    src2_value = b[W-1:0];
    stalls     = 0;
    @(negedge clk);
    while (!in_ready && stalls < 1000) begin
      stalls++;
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back(model(o, a, b));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  int st;
  int k;

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = '0; src1_value = '0; src2_value = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {27'd0, out_valid, flag_dz, flag_carry, flag_zero, 1'b0} | 32'(result), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    issue(ADD, 200, 100, st);
    check("add_latency1", 32'(out_valid), 32'd1);
    issue(SUB, 5, 7, st);
    issue(MUL, 20, 13, st);
    issue(MUL, 15, 17, st);
    issue(XOR, 8'hAA, 8'hAA, st);

    issue(DIV, 200, 7, st);
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1; k++;
      if (out_valid) break;
      check("div_busy_in_ready", 32'(in_ready), 32'd0);
    end
    check("div_latency", k, W);
    issue(REM, 200, 7, st);

    issue(DIV, 9, 0, st);
    check("dz_latency1", 32'(out_valid), 32'd1);
    issue(REM, 9, 0, st);

    issue(ADD, 1, 1, st);
    issue(ADD, 2, 2, st);
    check("b2b_stall_2", st, 0);
    issue(ADD, 3, 3, st);
    check("b2b_stall_3", st, 0);

    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(ADD, 5, 5, st);
    in_valid = 1'b1; op = ADD; src1_value = 8'd7; src2_value = 8'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_stable", {22'd0, out_valid, in_ready, result}, {22'd0, 1'b1, 1'b0, 8'd10});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(ADD, 7, 7, st);
    check("hold_release_stall", st, 0);

    @(posedge clk); #1;
    issue(DIV, 200, 7, st);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_state", {22'd0, out_valid, in_ready, result}, {22'd0, 1'b0, 1'b1, 8'd0});
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_output", 32'(out_valid), 32'd0);
    issue(ADD, 1, 1, st);

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [2:0] ro;
      int unsigned ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom_range(0, 255);
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      out_ready = ($urandom_range(0, 3) != 0);
      issue(ro, ra, rb, st);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
